// File: rtl/min_stream_pkg.sv
// Shared types and default widths for the streaming minimum tracker.
package min_stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_IDX_W = 8;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } min_state_t;

endpackage

// File: rtl/min_stream_tracker_min2.sv
// Two-input unsigned minimum selector; strict-less flag lets ties keep the incumbent.
module min2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic [WIDTH-1:0] y
);

    assign lt = (a < b);
    assign y  = lt ? a : b;

endmodule

// File: rtl/min_stream_tracker.sv
// Streaming minimum finder: tracks min value, first index, saturating count and
// overflow across a valid/ready frame, then holds the result until it is taken.
//
// state | meaning
// FIRST | waiting for the first sample of a frame
// ACCUM | folding further samples into the running minimum
// HOLD  | result presented, waiting for the consumer
module min_stream_tracker
    import min_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [IDX_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

    min_state_t       r_state;
    logic [WIDTH-1:0] r_min;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_lt;
    logic [WIDTH-1:0] w_y;
    logic             w_sat;

    min2 #(.WIDTH(WIDTH)) u_min2 (
        .a  (in_data),
        .b  (r_min),
        .lt (w_lt),
        .y  (w_y)
    );

    // Once saturated, r_cnt doubles as the reported index of any later minimum.
    assign w_sat = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FIRST;
            r_min   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                FIRST: begin
                    if (in_valid) begin
                        r_min   <= in_data;
                        r_idx   <= '0;
                        r_cnt   <= CNT_ONE;
                        r_ovf   <= 1'b0;
                        r_state <= in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (w_lt) begin
                            r_min <= w_y;
                            r_idx <= r_cnt;
                        end
                        if (w_sat) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        if (in_last) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= FIRST;
                    end
                end
                default: r_state <= FIRST;
            endcase
        end
    end

    // Handshake flags come straight from the state register, so neither
    // ready nor valid has a combinational path from the opposite side.
    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign out_min   = r_min;
    assign out_idx   = r_idx;
    assign out_cnt   = r_cnt;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_min_stream_tracker.sv
// Directed bench for min_stream_tracker: inputs change and outputs are sampled on the falling edge.
module tb_min_stream_tracker;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_min;
    logic [7:0] out_idx;
    logic [7:0] out_cnt;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready;

    int total;
    int bad;

    min_stream_tracker #(.WIDTH(8), .IDX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_min   (out_min),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic [7:0] d, input logic v, input logic l);
        in_data  = d;
        in_valid = v;
        in_last  = l;
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [7:0] m, input logic [7:0] i,
                                input logic [7:0] c, input logic o);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_min"},   32'(out_min),   32'(m));
        check({tag, "_idx"},   32'(out_idx),   32'(i));
        check({tag, "_cnt"},   32'(out_cnt),   32'(c));
        check({tag, "_ovf"},   32'(out_ovf),   32'(o));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_min",   32'(out_min),   32'd0);
        check("rst_idx",   32'(out_idx),   32'd0);
        check("rst_cnt",   32'(out_cnt),   32'd0);
        check("rst_ovf",   32'(out_ovf),   32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Basic frame 5,3,9,3,7
        out_ready = 1'b1;
        step(8'd5, 1'b1, 1'b0);
        check("b_run_min", 32'(out_min), 32'd5);
        step(8'd3, 1'b1, 1'b0);
        step(8'd9, 1'b1, 1'b0);
        step(8'd3, 1'b1, 1'b0);
        check("b_pre_valid", 32'(out_valid), 32'd0);
        check("b_tie_idx",   32'(out_idx),   32'd1);
        step(8'd7, 1'b1, 1'b1);
        check_result("basic", 8'd3, 8'd1, 8'd5, 1'b0);
        check("b_hold_ready", 32'(in_ready), 32'd0);
        step(8'd0, 1'b0, 1'b0);
        check("b_valid_drop", 32'(out_valid), 32'd0);
        check("b_ready_back", 32'(in_ready),  32'd1);

        // Single-sample frame
        step(8'h42, 1'b1, 1'b1);
        check_result("single", 8'h42, 8'd0, 8'd1, 1'b0);
        check("s_ready_low", 32'(in_ready), 32'd0);
        step(8'd0, 1'b0, 1'b0);
        check("s_ready_back", 32'(in_ready), 32'd1);
        check("s_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure: frame 8,2,6 then consumer stalls for four cycles
        out_ready = 1'b0;
        step(8'd8, 1'b1, 1'b0);
        step(8'd2, 1'b1, 1'b0);
        step(8'd6, 1'b1, 1'b1);
        check_result("bp", 8'd2, 8'd1, 8'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(8'd1, 1'b1, 1'b1);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
            check("bp_hold_min",   32'(out_min),   32'd2);
            check("bp_hold_idx",   32'(out_idx),   32'd1);
            check("bp_hold_cnt",   32'(out_cnt),   32'd3);
        end
        out_ready = 1'b1;
        step(8'd1, 1'b1, 1'b1);
        check("bp_taken_valid", 32'(out_valid), 32'd0);
        check("bp_not_consumed", 32'(out_min),  32'd2);
        step(8'd1, 1'b1, 1'b1);
        check_result("bp_next", 8'd1, 8'd0, 8'd1, 1'b0);
        step(8'd0, 1'b0, 1'b0);

        // Bubbles, stray last, then asynchronous reset mid-frame
        step(8'd10, 1'b1, 1'b0);
        step(8'd99, 1'b0, 1'b0);
        step(8'd4,  1'b1, 1'b0);
        step(8'd0,  1'b0, 1'b1);
        check("bub_min",   32'(out_min),   32'd4);
        check("bub_idx",   32'(out_idx),   32'd1);
        check("bub_cnt",   32'(out_cnt),   32'd2);
        check("bub_valid", 32'(out_valid), 32'd0);
        in_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_min",   32'(out_min),   32'd0);
        check("ar_idx",   32'(out_idx),   32'd0);
        check("ar_cnt",   32'(out_cnt),   32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_ready", 32'(in_ready),  32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(8'd9, 1'b1, 1'b0);
        step(8'd9, 1'b1, 1'b1);
        check_result("after_rst", 8'd9, 8'd0, 8'd2, 1'b0);
        step(8'd0, 1'b0, 1'b0);

        // 300-sample frame, minimum at position 280 after count saturation
        for (int i = 0; i < 300; i++) begin
            step((i == 280) ? 8'h01 : 8'hFF, 1'b1, (i == 299));
            if (i == 254) begin
                check("sat_cnt_255", 32'(out_cnt), 32'd255);
                check("sat_ovf_pre", 32'(out_ovf), 32'd0);
            end
            if (i == 255) begin
                check("sat_ovf_set", 32'(out_ovf), 32'd1);
                check("sat_cnt_hold", 32'(out_cnt), 32'd255);
            end
        end
        check_result("sat", 8'h01, 8'd255, 8'd255, 1'b1);
        step(8'd0, 1'b0, 1'b0);
        step(8'd5, 1'b1, 1'b0);
        check("ovf_cleared", 32'(out_ovf), 32'd0);
        step(8'd6, 1'b1, 1'b0);
        step(8'd7, 1'b1, 1'b1);
        check_result("post_sat", 8'd5, 8'd0, 8'd3, 1'b0);
        step(8'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
